arb_fifo: RTL and testbench
===========================

# arb_fifo

Synchronous first-word-fall-through FIFO directly downstream of the two-slave arbiter in the image-processing accelerator. Captures each arbitrated beat (data, mode, processing value, source slave) and presents it to the processing engine over a valid/ready handshake. Drives the `fifo_full` back-pressure the arbiter samples, with a configurable skid margin to absorb the arbiter's registered reaction latency.

## Interface
Parameters:
- `DW`, 32, pixel/data word width
- `DEPTH`, 16, entry count; power of two, ≥4
- `SKID`, 2, free entries still available when `fifo_full` asserts; 1 ≤ SKID < DEPTH

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `slvx_data`  in  DW  arbitrated data
- `slvx_data_valid`  in  1  push request
- `slvx_mode`  in  2  mode of beat
- `slvx_proc_val`  in  8  per-beat processing value
- `data_source`  in  1  0 = slave 0, 1 = slave 1
- `flush`  in  1  synchronous clear of contents
- `fifo_full`  out  1  back-pressure to arbiter
- `fifo_empty`  out  1  no entries held
- `out_data`  out  DW  head data
- `out_mode`  out  2  head mode
- `out_proc_val`  out  8  head processing value
- `out_source`  out  1  head source
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  consumer accepts head
- `overflow`  out  1  sticky: push dropped while hard-full
- `level`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Entry = {source, proc_val, mode, data}, 11+DW bits.
- Push: `slvx_data_valid` high at edge and `level < DEPTH` (hard-full not set) → entry written at wr_ptr, wr_ptr++.
- Push while `level == DEPTH` and no pop in same cycle → beat dropped, `overflow` set; stays set until reset or `flush`.
- Push with simultaneous pop at `level == DEPTH` → accepted (space freed same cycle); `level` unchanged.
- Pop: `out_valid && out_ready` at edge → rd_ptr++.
- Pointers are `$clog2(DEPTH)` bits, wrap DEPTH-1 → 0 naturally; `level` tracked as separate counter: +1 push only, −1 pop only, unchanged both/neither.
- `fifo_full` = `level >= DEPTH-SKID` (registered-level derived, combinational from `level`).
- `fifo_empty` = `level == 0`; `out_valid` = `!fifo_empty`.
- `out_*` fields = storage[rd_ptr] (FWFT); undefined content ignored when `out_valid` low.
- `flush`: pointers, `level`, `overflow` cleared next edge; concurrent push and pop in that cycle discarded. Flush has priority over push/pop.
- Reset mid-stream: identical effect to flush; storage contents not cleared.

## Timing
- Reset values: `fifo_full`=0, `fifo_empty`=1, `out_valid`=0, `overflow`=0, `level`=0; `out_data/out_mode/out_proc_val/out_source` don't-care (storage not reset).
- Push-to-output latency: entry pushed at edge N is visible on `out_*` with `out_valid`=1 after edge N (cycle N+1) when FIFO was empty.
- Push on empty with `out_ready` high: no same-cycle bypass; entry appears next cycle.
- `fifo_full` rises in the cycle after the push that brings `level` to DEPTH-SKID; arbiter may push up to SKID further beats without loss.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- `ARB_FIFO_STATS_EN` defined: adds outputs `drop_cnt` (16-bit, saturating, counts dropped pushes) and `high_water` (`$clog2(DEPTH)+1` bits, max `level` since reset/flush); both reset to 0 and cleared by `flush`.
- Not defined: those ports and registers absent; all other behaviour identical.

## Structure
- Package `arb_pkg`: `mode_t` (2-bit mode typedef, `MODE_IDLE`=2'b00), `src_t` (source typedef), `arb_entry_t` packed struct {src, proc_val, mode, data} parameterised via package `DW` constant, default DEPTH/SKID constants.
- Sub-module `arb_fifo_mem`: simple dual-port storage array, one write port, asynchronous read port, no reset.

## Test plan
- Reset then push 3 beats (data 0xA1,0xA2,0xA3, source 0,1,0) with `out_ready`=0 → `level`=3, `out_data`=0xA1, `out_source`=0, `fifo_full`=0.
- DEPTH=16, SKID=2: push 14 beats, `out_ready`=0 → `fifo_full` high from cycle after 14th push; 2 more pushes accepted, `level`=16, `overflow`=0.
- At `level`=16 push 1 beat, no pop → dropped, `overflow`=1, `level`=16; with STATS_EN `drop_cnt`=1.
- At `level`=16 push and pop in same cycle → `level`=16, `overflow`=0, head advances by one, new beat last out.
- Continuous push/pop 40 beats with pointer wrap, `out_ready`=1 → output sequence equals input sequence, `level` steady at 1.
- Fill 5, assert `flush` with simultaneous push → next cycle `level`=0, `fifo_empty`=1, `out_valid`=0, `overflow`=0.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared types for the arbiter-to-engine FIFO path.
// Optional statistics outputs are enabled with ARB_FIFO_STATS_EN.
package arb_pkg;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned SKID  = 2;

    // Bits carried alongside the data word: src(1) + proc_val(8) + mode(2).
    localparam int unsigned SIDEBAND_W = 11;

    typedef logic [1:0] mode_t;
    localparam mode_t MODE_IDLE = 2'b00;

    typedef logic src_t;

    typedef struct packed {
        src_t          src;
        logic [7:0]    proc_val;
        mode_t         mode;
        logic [DW-1:0] data;
    } arb_entry_t;

endpackage

// File: rtl/arb_fifo_if.sv
// arb_fifo_if: push side from the arbiter plus pop side to the processing engine.
// ARB_FIFO_STATS_EN adds the drop_cnt / high_water observation signals.
interface arb_fifo_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned LW = 5
);
    import arb_pkg::*;

    logic [DW-1:0] slvx_data;
    logic          slvx_data_valid;
    mode_t         slvx_mode;
    logic [7:0]    slvx_proc_val;
    src_t          data_source;
    logic          flush;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] out_data;
    mode_t         out_mode;
    logic [7:0]    out_proc_val;
    src_t          out_source;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
    logic [LW-1:0] level;
`ifdef ARB_FIFO_STATS_EN
    logic [15:0]   drop_cnt;
    logic [LW-1:0] high_water;
`endif

    // FIFO side: accepts beats, presents the head entry.
    modport slave (
        input  slvx_data, slvx_data_valid, slvx_mode, slvx_proc_val, data_source,
        input  flush, out_ready,
        output fifo_full, fifo_empty, out_data, out_mode, out_proc_val, out_source,
        output out_valid, overflow, level
`ifdef ARB_FIFO_STATS_EN
        , output drop_cnt, high_water
`endif
    );

    // Arbiter / engine side.
    modport master (
        output slvx_data, slvx_data_valid, slvx_mode, slvx_proc_val, data_source,
        output flush, out_ready,
        input  fifo_full, fifo_empty, out_data, out_mode, out_proc_val, out_source,
        input  out_valid, overflow, level
`ifdef ARB_FIFO_STATS_EN
        , input drop_cnt, high_water
`endif
    );

endinterface

// File: rtl/arb_fifo_mem.sv
// arb_fifo_mem: simple dual-port storage, one synchronous write, asynchronous read, no reset.
module arb_fifo_mem #(
    parameter int unsigned W     = 43,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/arb_fifo.sv
// arb_fifo: first-word-fall-through FIFO between the two-slave arbiter and the
// processing engine, with skid-margin back-pressure and sticky overflow.
// Define ARB_FIFO_STATS_EN to add drop_cnt and high_water statistics.
module arb_fifo
    import arb_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SKID  = 2
) (
    input logic        clk,
    input logic        rst_n,
    arb_fifo_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = DW + SIDEBAND_W;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          overflow_q, overflow_d;

    logic          hard_full_c;
    logic          pop_c;
    logic          push_ok_c;
    logic          drop_c;
    logic          we_c;
    logic [EW-1:0] wr_entry_c;
    logic [EW-1:0] rd_entry_c;

    // Handshake decode and next-state for pointers, occupancy and overflow; flush wins.
    always_comb begin
        hard_full_c = (level_q == LW'(DEPTH));
        pop_c       = (level_q != '0) && bus.out_ready;
        push_ok_c   = bus.slvx_data_valid && (!hard_full_c || pop_c);
        drop_c      = bus.slvx_data_valid && hard_full_c && !pop_c;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;

        if (bus.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_c)     rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok_c, pop_c})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (drop_c) overflow_d = 1'b1;
        end
    end

    // State registers; reset has the same effect as flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage write is suppressed when the beat is discarded by flush or reset.
    assign we_c       = push_ok_c && !bus.flush && rst_n;
    assign wr_entry_c = {bus.data_source, bus.slvx_proc_val, bus.slvx_mode, bus.slvx_data};

    arb_fifo_mem #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (we_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry_c),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry_c)
    );

    assign bus.out_source   = rd_entry_c[EW-1];
    assign bus.out_proc_val = rd_entry_c[EW-2 -: 8];
    assign bus.out_mode     = rd_entry_c[DW+1:DW];
    assign bus.out_data     = rd_entry_c[DW-1:0];

    // Status decoded from the registered occupancy.
    assign bus.fifo_full  = (level_q >= LW'(DEPTH - SKID));
    assign bus.fifo_empty = (level_q == '0);
    assign bus.out_valid  = (level_q != '0);
    assign bus.overflow   = overflow_q;
    assign bus.level      = level_q;

`ifdef ARB_FIFO_STATS_EN
    logic [15:0]   drop_cnt_q,   drop_cnt_d;
    logic [LW-1:0] high_water_q, high_water_d;

    // Saturating drop counter and peak occupancy tracker.
    always_comb begin
        drop_cnt_d   = drop_cnt_q;
        high_water_d = high_water_q;
        if (bus.flush) begin
            drop_cnt_d   = '0;
            high_water_d = '0;
        end else begin
            if (drop_c && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
            if (level_d > high_water_q) high_water_d = level_d;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q   <= '0;
            high_water_q <= '0;
        end else begin
            drop_cnt_q   <= drop_cnt_d;
            high_water_q <= high_water_d;
        end
    end

    assign bus.drop_cnt   = drop_cnt_q;
    assign bus.high_water = high_water_q;
`endif

endmodule

// File: tb/tb_arb_fifo.sv
// tb_arb_fifo: directed stimulus with a scoreboard queue of expected head entries;
// a forked monitor pops and compares on every accepted output beat.
// Define ARB_FIFO_STATS_EN to also check drop_cnt / high_water.
module tb_arb_fifo;
    import arb_pkg::*;

    localparam int unsigned TB_DW    = 32;
    localparam int unsigned TB_DEPTH = 16;
    localparam int unsigned TB_SKID  = 2;
    localparam int unsigned TB_LW    = $clog2(TB_DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    arb_fifo_if #(.DW(TB_DW), .LW(TB_LW)) bus ();

    arb_fifo #(
        .DW    (TB_DW),
        .DEPTH (TB_DEPTH),
        .SKID  (TB_SKID)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    arb_entry_t exp_q[$];
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic arb_entry_t mk(input logic [31:0] d, input logic s);
        arb_entry_t e;
        e.data     = d;
        e.mode     = mode_t'(d[1:0]);
        e.proc_val = 8'(d[7:0] ^ 8'h5A);
        e.src      = s;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one push beat for one cycle; accepted beats join the expected queue.
    task automatic push(input logic [31:0] d, input logic s, input bit accept);
        arb_entry_t e;
        e = mk(d, s);
        bus.slvx_data       = e.data;
        bus.slvx_mode       = e.mode;
        bus.slvx_proc_val   = e.proc_val;
        bus.data_source     = e.src;
        bus.slvx_data_valid = 1'b1;
        if (accept) exp_q.push_back(e);
        tick();
        bus.slvx_data_valid = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        exp_q.delete();
        tick();
        bus.flush = 1'b0;
    endtask

    // Compares the head on every cycle where the consumer accepts it.
    task automatic monitor();
        arb_entry_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !bus.flush && bus.out_valid && bus.out_ready) begin
                check("pop_has_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data",     bus.out_data,     e.data);
                    check("out_mode",     bus.out_mode,     e.mode);
                    check("out_proc_val", bus.out_proc_val, e.proc_val);
                    check("out_source",   bus.out_source,   e.src);
                end
            end
        end
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.flush           = 1'b0;
        bus.out_ready       = 1'b0;
        bus.slvx_data_valid = 1'b0;
        bus.slvx_data       = '0;
        bus.slvx_mode       = MODE_IDLE;
        bus.slvx_proc_val   = '0;
        bus.data_source     = 1'b0;

        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (3) tick();
        check("rst_level",     bus.level,      0);
        check("rst_empty",     bus.fifo_empty, 1);
        check("rst_out_valid", bus.out_valid,  0);
        check("rst_full",      bus.fifo_full,  0);
        check("rst_overflow",  bus.overflow,   0);
        rst_n = 1'b1;
        tick();

        // Three beats, consumer stalled, then drain
        push(32'hA1, 1'b0, 1);
        check("lat_valid_after_first", bus.out_valid, 1);
        push(32'hA2, 1'b1, 1);
        push(32'hA3, 1'b0, 1);
        check("t1_level",     bus.level,      3);
        check("t1_out_data",  bus.out_data,   32'hA1);
        check("t1_out_src",   bus.out_source, 0);
        check("t1_full",      bus.fifo_full,  0);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        bus.out_ready = 1'b0;
        check("t1_drained_empty", bus.fifo_empty, 1);

        // Fill to the skid threshold, then use the skid
        for (int i = 0; i < 14; i++) begin
            push(32'h100 + 32'(i), 1'(i), 1);
            if (i == 12) check("t2_full_at_13", bus.fifo_full, 0);
        end
        check("t2_full_at_14",  bus.fifo_full, 1);
        check("t2_level_14",    bus.level,     14);
        push(32'h10E, 1'b0, 1);
        push(32'h10F, 1'b1, 1);
        check("t2_level_16",    bus.level,     16);
        check("t2_overflow_0",  bus.overflow,  0);

        // Push at hard-full with no pop is dropped
        push(32'h1FF, 1'b0, 0);
        check("t3_overflow",    bus.overflow,  1);
        check("t3_level",       bus.level,     16);
        check("t3_head",        bus.out_data,  32'h100);
`ifdef ARB_FIFO_STATS_EN
        check("t3_drop_cnt",    bus.drop_cnt,   1);
        check("t3_high_water",  bus.high_water, 16);
`endif

        // Flush clears overflow; refill and push+pop at full
        do_flush();
        check("t4_flush_level",    bus.level,    0);
        check("t4_flush_overflow", bus.overflow, 0);
`ifdef ARB_FIFO_STATS_EN
        check("t4_flush_drop_cnt", bus.drop_cnt, 0);
`endif
        for (int i = 0; i < 16; i++) push(32'h200 + 32'(i), 1'(i), 1);
        check("t4_level_16", bus.level, 16);
        bus.out_ready = 1'b1;
        push(32'h2FF, 1'b1, 1);
        bus.out_ready = 1'b0;
        check("t4_level_same", bus.level,    16);
        check("t4_overflow",   bus.overflow, 0);
        check("t4_head_adv",   bus.out_data, 32'h201);
        bus.out_ready = 1'b1;
        repeat (16) tick();
        bus.out_ready = 1'b0;
        check("t4_drained_empty", bus.fifo_empty, 1);
        check("t4_queue_empty",   exp_q.size(),   0);

        // Streaming with pointer wrap
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(32'h300 + 32'(i), 1'(i >> 1), 1);
            check("t5_level_steady", bus.level, 1);
        end
        tick();
        bus.out_ready = 1'b0;
        check("t5_empty",       bus.fifo_empty, 1);
        check("t5_queue_empty", exp_q.size(),   0);

        // Flush with simultaneous push
        for (int i = 0; i < 5; i++) push(32'h400 + 32'(i), 1'b0, 1);
        check("t6_level_5", bus.level, 5);
        bus.slvx_data       = 32'h4FF;
        bus.slvx_data_valid = 1'b1;
        do_flush();
        bus.slvx_data_valid = 1'b0;
        check("t6_level",     bus.level,      0);
        check("t6_empty",     bus.fifo_empty, 1);
        check("t6_out_valid", bus.out_valid,  0);
        check("t6_overflow",  bus.overflow,   0);
        tick();
        check("t6_level_hold", bus.level, 0);

        // Reset mid-stream behaves like flush; FIFO usable afterwards
        push(32'h500, 1'b1, 1);
        push(32'h501, 1'b0, 1);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        check("t7_rst_level", bus.level,      0);
        check("t7_rst_empty", bus.fifo_empty, 1);
        push(32'h5A5, 1'b1, 1);
        check("t7_level_1", bus.level, 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t7_empty",       bus.fifo_empty, 1);
        check("t7_queue_empty", exp_q.size(),   0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
